// File: rtl/interval_meter_pkg.sv
// Shared definitions for the interval meter: FSM state encoding.
// Guarded so repeated inclusion in a file list is harmless.
`ifndef INTERVAL_METER_PKG_SV
`define INTERVAL_METER_PKG_SV
package interval_meter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage
`endif

// File: rtl/interval_meter_countup.sv
// Edge counter with synchronous clear and enable. INTERVAL_METER_OVF_EN adds
// saturation at all-ones and exposes the saturated flag.
module countup #(
  parameter int W = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] nxt
`ifdef INTERVAL_METER_OVF_EN
  ,
  output logic         sat
`endif
);

  logic [W-1:0] count_q, count_d;

  // nxt is the count one edge later; shared by the increment and by the
  // top-level result capture so there is a single adder.
`ifdef INTERVAL_METER_OVF_EN
  assign sat = (count_q == {W{1'b1}});
  assign nxt = sat ? count_q : count_q + 1'b1;
`else
  assign nxt = count_q + 1'b1;
`endif

  always_comb begin
    count_d = count_q;
    if (clr)     count_d = '0;
    else if (en) count_d = nxt;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) count_q <= '0;
    else        count_q <= count_d;
  end

endmodule

// File: rtl/interval_meter.sv
// Measures edges from a start event to a stop event and holds the result
// until taken. INTERVAL_METER_OVF_EN enables saturation and the over port.
module interval_meter
  import interval_meter_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         start,
  input  logic         stop,
  input  logic         get,
  output logic [W-1:0] value,
  output logic         full,
  output logic         busy
`ifdef INTERVAL_METER_OVF_EN
  ,
  output logic         over
`endif
);

  state_e       state_q, state_d;
  logic [W-1:0] value_q, value_d;
  logic         full_q, full_d;
  logic         busy_q, busy_d;
  logic         cnt_clr, cnt_en;
  logic [W-1:0] cnt_nxt;
`ifdef INTERVAL_METER_OVF_EN
  logic         cnt_sat;
  logic         over_q, over_d;
`endif

  countup #(.W(W)) u_cnt (
    .clock (clock),
    .reset (reset),
    .clr   (cnt_clr),
    .en    (cnt_en),
    .nxt   (cnt_nxt)
`ifdef INTERVAL_METER_OVF_EN
    ,
    .sat   (cnt_sat)
`endif
  );

  always_comb begin
    state_d = state_q;
    value_d = value_q;
    cnt_clr = 1'b0;
    cnt_en  = 1'b0;
`ifdef INTERVAL_METER_OVF_EN
    over_d  = over_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          cnt_clr = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        // stop has priority over a simultaneous restart
        if (stop) begin
          value_d = cnt_nxt;
`ifdef INTERVAL_METER_OVF_EN
          over_d  = cnt_sat;
`endif
          state_d = DONE;
        end else if (start) begin
          cnt_clr = 1'b1;
        end else begin
          cnt_en = 1'b1;
        end
      end
      DONE: begin
        if (get) begin
          if (start) begin
            cnt_clr = 1'b1;
            state_d = RUN;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == RUN);
    full_d = (state_d == DONE);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      value_q <= '0;
      full_q  <= 1'b0;
      busy_q  <= 1'b0;
`ifdef INTERVAL_METER_OVF_EN
      over_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      value_q <= value_d;
      full_q  <= full_d;
      busy_q  <= busy_d;
`ifdef INTERVAL_METER_OVF_EN
      over_q  <= over_d;
`endif
    end
  end

  assign value = value_q;
  assign full  = full_q;
  assign busy  = busy_q;
`ifdef INTERVAL_METER_OVF_EN
  assign over  = over_q;
`endif

endmodule
